// File: rtl/rv32i_dbus_bridge_if.sv
// Signal bundle between the RV32I data port, the bridge and the system data bus.
// The master modport is the bridge's view: slave to the core, master on the bus.
// The slave modport is the environment's view: the core plus the bus target.
interface rv32i_dbus_bridge_if;
    // Core side
    logic [31:0] daddress;
    logic        dwrite;
    logic [31:0] dwritedata;
    logic [3:0]  dbyteenable;
    logic        dread;
    logic [31:0] dreaddata;
    logic        dwaitrequest;
    // System bus side
    logic [31:0] m_address;
    logic        m_write;
    logic [31:0] m_writedata;
    logic [3:0]  m_byteenable;
    logic        m_read;
    logic        m_waitrequest;
    logic [31:0] m_readdata;
    logic        m_readdatavalid;

    modport master (
        input  daddress, dwrite, dwritedata, dbyteenable, dread,
        output dreaddata, dwaitrequest,
        output m_address, m_write, m_writedata, m_byteenable, m_read,
        input  m_waitrequest, m_readdata, m_readdatavalid
    );

    modport slave (
        output daddress, dwrite, dwritedata, dbyteenable, dread,
        input  dreaddata, dwaitrequest,
        input  m_address, m_write, m_writedata, m_byteenable, m_read,
        output m_waitrequest, m_readdata, m_readdatavalid
    );
endinterface

// File: rtl/rv32i_dbus_bridge.sv
// RV32I data-port bridge: stores are posted into a write FIFO, loads wait for
// the FIFO to drain and are then issued as pipelined reads with readdatavalid.
module rv32i_dbus_bridge #(
    parameter int unsigned LOG2_WFIFO_DEPTH = 2
) (
    input  logic                      clk,
    input  logic                      reset_n,
    rv32i_dbus_bridge_if.master       bus,
    output logic                      wr_overflow,
    output logic [LOG2_WFIFO_DEPTH:0] wfifo_level
);
    localparam int unsigned Depth = 1 << LOG2_WFIFO_DEPTH;
    localparam int unsigned PtrW  = LOG2_WFIFO_DEPTH;
    localparam int unsigned CntW  = LOG2_WFIFO_DEPTH + 1;

    typedef enum logic [2:0] {StIdle, StDrain, StIssue, StWaitData, StResp} state_e;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } wentry_t;

    wentry_t         mem_q [Depth];
    wentry_t         head;
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic            overflow_q, overflow_d;
    logic            fifo_empty, fifo_full, pop, push_ok;

    state_e          state_q, state_d;
    logic [31:0]     raddr_q, raddr_d;
    logic [31:0]     rdata_q, rdata_d;
    logic            m_read_q, m_read_d;
    logic            dwait_q, dwait_d;

    // Bus-facing outputs; a write may only go out while no load owns the bus.
    always_comb begin
        head        = mem_q[rd_ptr_q];
        fifo_empty  = (count_q == '0);
        fifo_full   = (count_q == CntW'(Depth));
        bus.m_write = ~fifo_empty & ((state_q == StIdle) | (state_q == StDrain));
        bus.m_read  = m_read_q;
        if (bus.m_write) begin
            bus.m_address    = head.addr;
            bus.m_writedata  = head.data;
            bus.m_byteenable = head.be;
        end else if (m_read_q) begin
            bus.m_address    = raddr_q;
            bus.m_writedata  = '0;
            bus.m_byteenable = 4'hF;
        end else begin
            bus.m_address    = '0;
            bus.m_writedata  = '0;
            bus.m_byteenable = '0;
        end
        bus.dreaddata    = rdata_q;
        bus.dwaitrequest = dwait_q;
        wr_overflow      = overflow_q;
        wfifo_level      = count_q;
    end

    // FIFO next state; a push into a full FIFO survives only if the head pops.
    always_comb begin
        pop        = bus.m_write & ~bus.m_waitrequest;
        push_ok    = bus.dwrite & (~fifo_full | pop);
        wr_ptr_d   = wr_ptr_q + PtrW'(push_ok);
        rd_ptr_d   = rd_ptr_q + PtrW'(pop);
        count_d    = count_q + CntW'(push_ok) - CntW'(pop);
        overflow_d = overflow_q | (bus.dwrite & fifo_full & ~pop);
    end

    // FIFO pointers, occupancy and sticky overflow.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // FIFO storage; contents are don't-care once the pointers are reset.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= '{addr: bus.daddress, data: bus.dwritedata, be: bus.dbyteenable};
        end
    end

    // Load sequencing: drain posted stores, issue, wait for data, respond once.
    always_comb begin
        state_d = state_q;
        raddr_d = raddr_q;
        rdata_d = rdata_q;
        unique case (state_q)
            StIdle: begin
                if (bus.dread) begin
                    raddr_d = bus.daddress;
                    // A same-cycle store is older than the load, so it drains first.
                    state_d = (!fifo_empty || bus.dwrite) ? StDrain : StIssue;
                end
            end
            StDrain: begin
                if (fifo_empty && !bus.dwrite) state_d = StIssue;
            end
            StIssue: begin
                if (!bus.m_waitrequest) state_d = StWaitData;
            end
            StWaitData: begin
                if (bus.m_readdatavalid) begin
                    rdata_d = bus.m_readdata;
                    state_d = StResp;
                end
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
        m_read_d = (state_d == StIssue);
        dwait_d  = (state_d != StResp);
    end

    // Read FSM state and its registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= StIdle;
            raddr_q  <= '0;
            rdata_q  <= '0;
            m_read_q <= 1'b0;
            dwait_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            raddr_q  <= raddr_d;
            rdata_q  <= rdata_d;
            m_read_q <= m_read_d;
            dwait_q  <= dwait_d;
        end
    end
endmodule

// File: tb/tb_rv32i_dbus_bridge.sv
// Bench for rv32i_dbus_bridge: directed scenarios with literal expectations,
// then randomized core/bus traffic, all checked every cycle against a queue model.
module tb_rv32i_dbus_bridge;
    localparam int Depth = 4;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       wr_overflow;
    logic [2:0] wfifo_level;

    rv32i_dbus_bridge_if bif ();

    rv32i_dbus_bridge #(.LOG2_WFIFO_DEPTH(2)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .bus        (bif),
        .wr_overflow(wr_overflow),
        .wfifo_level(wfifo_level)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  be;
    } wr_t;

    wr_t         mq[$];
    int          m_ph;       // 0 idle, 1 drain, 2 issue, 3 wait data, 4 respond
    logic [31:0] m_raddr;
    logic [31:0] m_rdata;
    bit          m_ovf;

    function automatic void model_reset();
        mq.delete();
        m_ph    = 0;
        m_raddr = '0;
        m_rdata = '0;
        m_ovf   = 1'b0;
    endfunction

    function automatic bit model_wr();
        return (mq.size() > 0) && (m_ph <= 1);
    endfunction

    function automatic void model_step();
        bit pop;
        bit full;
        int nph;
        pop  = model_wr() && !bif.m_waitrequest;
        full = (mq.size() == Depth);
        nph  = m_ph;
        case (m_ph)
            0: if (bif.dread) begin
                m_raddr = bif.daddress;
                nph = (mq.size() > 0 || bif.dwrite) ? 1 : 2;
            end
            1: if (mq.size() == 0 && !bif.dwrite) nph = 2;
            2: if (!bif.m_waitrequest) nph = 3;
            3: if (bif.m_readdatavalid) begin
                m_rdata = bif.m_readdata;
                nph = 4;
            end
            default: nph = 0;
        endcase
        if (pop) void'(mq.pop_front());
        if (bif.dwrite) begin
            if (full && !pop) m_ovf = 1'b1;
            else mq.push_back({bif.daddress, bif.dwritedata, bif.dbyteenable});
        end
        m_ph = nph;
    endfunction

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) model_reset();
            else model_step();
        end
    end

    // ---------------- per-cycle compare ----------------
    bit          e_wr;
    logic [31:0] e_a;
    logic [31:0] e_d;
    logic [3:0]  e_be;

    initial forever begin
        @(negedge clk);
        e_wr = model_wr();
        if (e_wr) begin
            e_a = mq[0].a; e_d = mq[0].d; e_be = mq[0].be;
        end else if (m_ph == 2) begin
            e_a = m_raddr; e_d = '0; e_be = 4'hF;
        end else begin
            e_a = '0; e_d = '0; e_be = '0;
        end
        chk("m_write", 32'(bif.m_write), 32'(e_wr));
        chk("m_read", 32'(bif.m_read), 32'(m_ph == 2));
        chk("m_address", bif.m_address, e_a);
        chk("m_writedata", bif.m_writedata, e_d);
        chk("m_byteenable", 32'(bif.m_byteenable), 32'(e_be));
        chk("dwaitrequest", 32'(bif.dwaitrequest), 32'(m_ph != 4));
        chk("dreaddata", bif.dreaddata, m_rdata);
        chk("wr_overflow", 32'(wr_overflow), 32'(m_ovf));
        chk("wfifo_level", 32'(wfifo_level), 32'(mq.size()));
        chk("rw_overlap", 32'(bif.m_read & bif.m_write), 32'h0);
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bif.daddress        = '0;
        bif.dwrite          = 1'b0;
        bif.dwritedata      = '0;
        bif.dbyteenable     = '0;
        bif.dread           = 1'b0;
        bif.m_waitrequest   = 1'b0;
        bif.m_readdata      = '0;
        bif.m_readdatavalid = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_m_read"}, 32'(bif.m_read), 32'h0);
        chk({tag, "_m_write"}, 32'(bif.m_write), 32'h0);
        chk({tag, "_m_address"}, bif.m_address, 32'h0);
        chk({tag, "_m_writedata"}, bif.m_writedata, 32'h0);
        chk({tag, "_dwait"}, 32'(bif.dwaitrequest), 32'h1);
        chk({tag, "_dreaddata"}, bif.dreaddata, 32'h0);
        chk({tag, "_ovf"}, 32'(wr_overflow), 32'h0);
        chk({tag, "_level"}, 32'(wfifo_level), 32'h0);
    endtask

    task automatic do_reset();
        idle_inputs();
        reset_n = 1'b0;
        tick();
        chk_reset_vals("rst");
        reset_n = 1'b1;
        tick();
    endtask

    logic [3:0] be_tab [3];
    int         rd_cnt;
    int         wprob;
    bit         acc;
    bit         resp;

    initial begin
        be_tab[0] = 4'h1; be_tab[1] = 4'h3; be_tab[2] = 4'hF;
        do_reset();

        // Single load, latency 1.
        bif.dread = 1'b1; bif.daddress = 32'h40;
        tick();                                                    // cycle 1
        chk("t1_mread_c1", 32'(bif.m_read), 32'h1);
        chk("t1_maddr_c1", bif.m_address, 32'h40);
        chk("t1_dwait_c1", 32'(bif.dwaitrequest), 32'h1);
        tick();                                                    // cycle 2
        chk("t1_mread_c2", 32'(bif.m_read), 32'h0);
        bif.m_readdatavalid = 1'b1; bif.m_readdata = 32'hDEADBEEF;
        tick();                                                    // cycle 3
        bif.m_readdatavalid = 1'b0;
        chk("t1_dwait_c3", 32'(bif.dwaitrequest), 32'h0);
        chk("t1_rdata_c3", bif.dreaddata, 32'hDEADBEEF);
        tick();                                                    // cycle 4
        bif.dread = 1'b0;
        chk("t1_dwait_c4", 32'(bif.dwaitrequest), 32'h1);

        // Three stores while the bus stalls.
        bif.m_waitrequest = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bif.dwrite = 1'b1; bif.daddress = 32'h100 + 32'(4 * i);
            bif.dwritedata = 32'hA000_0100 + 32'(4 * i); bif.dbyteenable = be_tab[i];
            tick();
        end
        bif.dwrite = 1'b0;
        chk("t2_level_peak", 32'(wfifo_level), 32'h3);
        bif.m_waitrequest = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("t2_mwrite", 32'(bif.m_write), 32'h1);
            chk("t2_addr", bif.m_address, 32'h100 + 32'(4 * i));
            chk("t2_data", bif.m_writedata, 32'hA000_0100 + 32'(4 * i));
            chk("t2_be", 32'(bif.m_byteenable), 32'(be_tab[i]));
            tick();
        end
        chk("t2_level_end", 32'(wfifo_level), 32'h0);
        chk("t2_mwrite_end", 32'(bif.m_write), 32'h0);

        // Store then load of the same address.
        bif.dwrite = 1'b1; bif.daddress = 32'h200; bif.dwritedata = 32'h1234_5678;
        bif.dbyteenable = 4'hF;
        tick();                                                    // cycle 1
        bif.dwrite = 1'b0; bif.dread = 1'b1;
        chk("t3_mwrite_c1", 32'(bif.m_write), 32'h1);
        chk("t3_maddr_c1", bif.m_address, 32'h200);
        chk("t3_mread_c1", 32'(bif.m_read), 32'h0);
        tick();                                                    // cycle 2
        chk("t3_mread_c2", 32'(bif.m_read), 32'h0);
        chk("t3_level_c2", 32'(wfifo_level), 32'h0);
        tick();                                                    // cycle 3
        chk("t3_mread_c3", 32'(bif.m_read), 32'h1);
        chk("t3_maddr_c3", bif.m_address, 32'h200);
        tick();                                                    // cycle 4
        bif.m_readdatavalid = 1'b1; bif.m_readdata = 32'hCAFE_F00D;
        tick();                                                    // cycle 5
        bif.m_readdatavalid = 1'b0;
        chk("t3_dwait_c5", 32'(bif.dwaitrequest), 32'h0);
        chk("t3_rdata_c5", bif.dreaddata, 32'hCAFE_F00D);
        tick();
        bif.dread = 1'b0;

        // Fill to full, push-with-pop at full, then a dropped push.
        do_reset();
        bif.m_waitrequest = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bif.dwrite = 1'b1; bif.daddress = 32'h300 + 32'(4 * i);
            bif.dwritedata = 32'hB000_0000 + 32'(i); bif.dbyteenable = 4'hF;
            tick();
        end
        chk("t5_level_full", 32'(wfifo_level), 32'h4);
        bif.daddress = 32'h310; bif.dwritedata = 32'hB000_0004; bif.m_waitrequest = 1'b0;
        tick();
        chk("t5_level_pushpop", 32'(wfifo_level), 32'h4);
        chk("t5_ovf_pushpop", 32'(wr_overflow), 32'h0);
        bif.daddress = 32'h3F0; bif.dwritedata = 32'hDEAD_0000; bif.m_waitrequest = 1'b1;
        tick();
        bif.dwrite = 1'b0;
        chk("t4_level_drop", 32'(wfifo_level), 32'h4);
        chk("t4_ovf_drop", 32'(wr_overflow), 32'h1);
        bif.m_waitrequest = 1'b0;
        for (int i = 1; i < 5; i++) begin
            chk("t4_mwrite", 32'(bif.m_write), 32'h1);
            chk("t4_addr", bif.m_address, 32'h300 + 32'(4 * i));
            tick();
        end
        chk("t4_level_end", 32'(wfifo_level), 32'h0);
        chk("t4_ovf_sticky", 32'(wr_overflow), 32'h1);

        // Load: bus stalls 3 cycles, then latency 4.
        bif.dread = 1'b1; bif.daddress = 32'h480; bif.m_waitrequest = 1'b1;
        tick();                                                    // cycle 1
        for (int i = 0; i < 4; i++) begin
            chk("t6_mread_held", 32'(bif.m_read), 32'h1);
            chk("t6_maddr_held", bif.m_address, 32'h480);
            if (i == 3) bif.m_waitrequest = 1'b0;
            tick();
        end
        for (int i = 0; i < 3; i++) begin                          // cycles 5..7
            chk("t6_mread_wait", 32'(bif.m_read), 32'h0);
            chk("t6_dwait_wait", 32'(bif.dwaitrequest), 32'h1);
            tick();
        end
        bif.m_readdatavalid = 1'b1; bif.m_readdata = 32'h0BAD_CAFE;  // cycle 8
        chk("t6_dwait_c8", 32'(bif.dwaitrequest), 32'h1);
        tick();                                                    // cycle 9
        bif.m_readdatavalid = 1'b0;
        chk("t6_dwait_c9", 32'(bif.dwaitrequest), 32'h0);
        chk("t6_rdata_c9", bif.dreaddata, 32'h0BAD_CAFE);
        tick();
        bif.dread = 1'b0;
        chk("t6_dwait_c10", 32'(bif.dwaitrequest), 32'h1);

        // Reset during WAIT_DATA with a queued store, then a stale response.
        bif.dread = 1'b1; bif.daddress = 32'h500; bif.m_waitrequest = 1'b0;
        tick();                                                    // cycle 1, issue
        bif.dwrite = 1'b1; bif.dwritedata = 32'h55; bif.dbyteenable = 4'hF;
        tick();                                                    // cycle 2, wait data
        bif.dwrite = 1'b0;
        chk("t7_level_queued", 32'(wfifo_level), 32'h1);
        chk("t7_mwrite_queued", 32'(bif.m_write), 32'h0);
        #2 reset_n = 1'b0;
        #1 chk_reset_vals("t7_inrst");
        tick();
        reset_n = 1'b1; bif.dread = 1'b0;
        bif.m_readdatavalid = 1'b1; bif.m_readdata = 32'hBAD0_BAD0;
        tick();
        bif.m_readdatavalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("t7_dwait_after", 32'(bif.dwaitrequest), 32'h1);
            chk("t7_rdata_after", bif.dreaddata, 32'h0);
            tick();
        end

        // Randomized traffic.
        do_reset();
        rd_cnt = -1;
        acc = 1'b0;
        resp = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            wprob = ((n / 500) % 3 == 0) ? 10 : (((n / 500) % 3 == 1) ? 50 : 85);
            if (resp) bif.dread = 1'b0;
            else if (!bif.dread && $urandom_range(0, 3) == 0) begin
                bif.dread = 1'b1;
                bif.daddress = 32'($urandom_range(0, 63)) << 2;
            end
            if (!bif.dread) bif.daddress = 32'($urandom_range(0, 63)) << 2;
            bif.dwrite      = ($urandom_range(0, 9) < 4);
            bif.dwritedata  = $urandom;
            bif.dbyteenable = 4'($urandom);
            bif.m_waitrequest = ($urandom_range(0, 99) < wprob);
            if (acc) rd_cnt = $urandom_range(0, 3);
            bif.m_readdata = $urandom;
            if (rd_cnt == 0) begin
                bif.m_readdatavalid = 1'b1;
                rd_cnt = -1;
            end else begin
                bif.m_readdatavalid = (rd_cnt < 0) && (m_ph != 3) && ($urandom_range(0, 19) == 0);
                if (rd_cnt > 0) rd_cnt--;
            end
            acc  = bif.m_read && !bif.m_waitrequest;
            resp = bif.dread && !bif.dwaitrequest;
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
